// File: rtl/weight_stationary_array.sv
// 2x2 weight-stationary systolic MAC array: fetches a weight tile from weight_memory,
// then streams signed activation vectors through it (y = x * W) with a fixed 3-cycle latency.
//
// state   | meaning
// IDLE    | no tile loaded yet, vectors refused
// FETCH   | w_addr presented, memory registering the tile
// CAPTURE | memory data valid, latched into the weight registers
// READY   | tile resident, one vector accepted per cycle
// DRAIN   | new load pending, waiting for in-flight vectors to leave
module weight_stationary_array #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int ADDR_W = 16,
  parameter int LAT    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_req_i,
  input  logic [ADDR_W-1:0]        w_base_i,
  output logic [ADDR_W-1:0]        w_addr_o,
  input  logic signed [DATA_W-1:0] w1_i,
  input  logic signed [DATA_W-1:0] w2_i,
  input  logic signed [DATA_W-1:0] w3_i,
  input  logic signed [DATA_W-1:0] w4_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] x0_i,
  input  logic signed [DATA_W-1:0] x1_i,
  output logic                     out_valid_o,
  output logic signed [ACC_W-1:0]  y0_o,
  output logic signed [ACC_W-1:0]  y1_o,
  output logic                     busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_READY   = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam int PW = 2 * DATA_W;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]        w_addr_q;
  logic signed [DATA_W-1:0] w00_q, w01_q, w10_q, w11_q;
  logic [LAT-1:0]           vld_q;

  logic signed [PW-1:0]     p00_q, p01_q, p01d_q;
  logic signed [DATA_W-1:0] x1s_q, x1d_q;
  logic signed [ACC_W-1:0]  s0_q, y0_q, y1_q;

  logic accept;
  logic pipe_busy;
  logic latch_base;
  logic capture;

  // Operands widened first so the product is formed at full 2*DATA_W width.
  function automatic logic signed [PW-1:0] smul(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [PW-1:0] p);
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  assign pipe_busy = |vld_q;
  assign accept    = in_valid_i & in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load_req_i) state_d = S_FETCH;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_READY;
      S_READY: begin
        // A vector accepted alongside the load still has to finish on the old tile.
        if (load_req_i) state_d = (accept || pipe_busy) ? S_DRAIN : S_FETCH;
      end
      S_DRAIN:   if (!pipe_busy) state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == S_READY);
    busy_o     = !((state_q == S_READY) || ((state_q == S_IDLE) && !pipe_busy));
    latch_base = load_req_i && ((state_q == S_IDLE) || (state_q == S_READY));
    capture    = (state_q == S_CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr_q <= '0;
      w00_q    <= '0;
      w01_q    <= '0;
      w10_q    <= '0;
      w11_q    <= '0;
    end else begin
      if (latch_base) w_addr_q <= w_base_i;
      if (capture) begin
        w00_q <= w1_i;
        w01_q <= w2_i;
        w10_q <= w3_i;
        w11_q <= w4_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], accept};
    end
  end

  // Row 0 multiplies on entry; row 1 and column 1 see their operands one stage later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p00_q  <= '0;
      p01_q  <= '0;
      x1s_q  <= '0;
      s0_q   <= '0;
      p01d_q <= '0;
      x1d_q  <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
    end else begin
      if (accept) begin
        p00_q <= smul(x0_i, w00_q);
        p01_q <= smul(x0_i, w01_q);
        x1s_q <= x1_i;
      end
      if (vld_q[0]) begin
        s0_q   <= sext(p00_q) + sext(smul(x1s_q, w10_q));
        p01d_q <= p01_q;
        x1d_q  <= x1s_q;
      end
      if (vld_q[1]) begin
        y0_q <= s0_q;
        y1_q <= sext(p01d_q) + sext(smul(x1d_q, w11_q));
      end
    end
  end

  assign w_addr_o    = w_addr_q;
  assign out_valid_o = vld_q[LAT-1];
  assign y0_o        = y0_q;
  assign y1_o        = y1_q;

endmodule

// File: tb/tb_weight_stationary_array.sv
// Self-checking bench for weight_stationary_array: directed tiles plus random traffic,
// checked every cycle against a transaction-level model of the array.
module tb_weight_stationary_array;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_req = 1'b0;
  logic [15:0]        w_base = '0;
  logic [15:0]        w_addr;
  logic signed [7:0]  w1, w2, w3, w4;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  x0 = '0, x1 = '0;
  logic               out_valid;
  logic signed [17:0] y0, y1;
  logic               busy;

  weight_stationary_array #(.DATA_W(8), .ACC_W(18), .ADDR_W(16), .LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_req_i(load_req), .w_base_i(w_base), .w_addr_o(w_addr),
    .w1_i(w1), .w2_i(w2), .w3_i(w3), .w4_i(w4),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x0_i(x0), .x1_i(x1),
    .out_valid_o(out_valid), .y0_o(y0), .y1_o(y1), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // weight_memory stand-in: registered read, 16 tiles selected by the low address bits
  int mem [16][4];
  always @(posedge clk) begin
    w1 <= 8'(mem[w_addr[3:0]][0]);
    w2 <= 8'(mem[w_addr[3:0]][1]);
    w3 <= 8'(mem[w_addr[3:0]][2]);
    w4 <= 8'(mem[w_addr[3:0]][3]);
  end

  typedef struct { int due; int y0; int y1; } exp_t;

  int   n_checks = 0, n_pass = 0, n_fail = 0;
  int   cyc;
  bit   loaded;
  int   ready_at, last_due;
  int   cw[4], nw[4];
  int   y0_last, y1_last;
  logic [15:0] addr_exp;
  exp_t q[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    loaded = 0; ready_at = 0; last_due = -100;
    y0_last = 0; y1_last = 0; addr_exp = '0;
    for (int i = 0; i < 4; i++) begin cw[i] = 0; nw[i] = 0; end
  endtask

  function automatic int rs8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // One clock cycle: check this cycle's outputs, drive inputs, advance the model, step the clock.
  task automatic cycle(input bit ld, input logic [15:0] base, input bit iv, input int a0, input int a1);
    bit   exp_ready, exp_ov, acc;
    exp_t e;
    if (loaded && cyc >= ready_at) cw = nw;
    exp_ready = loaded && (cyc >= ready_at);
    exp_ov = (q.size() > 0) && (q[0].due == cyc);
    if (exp_ov) begin
      y0_last = q[0].y0; y1_last = q[0].y1;
      void'(q.pop_front());
    end
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_ov);
    chk("y0", y0, y0_last);
    chk("y1", y1, y1_last);
    chk("w_addr", w_addr, addr_exp);
    chk("busy", busy, loaded && (cyc < ready_at));

    load_req = ld; w_base = base; in_valid = iv;
    x0 = a0[7:0]; x1 = a1[7:0];

    acc = iv && exp_ready;
    if (acc) begin
      e.due = cyc + 3;
      e.y0 = a0 * cw[0] + a1 * cw[2];
      e.y1 = a0 * cw[1] + a1 * cw[3];
      q.push_back(e);
    end
    if (ld && (!loaded || exp_ready)) begin
      addr_exp = base;
      for (int i = 0; i < 4; i++) nw[i] = mem[base[3:0]][i];
      // Loading over in-flight vectors: wait out the last result, then a 3-cycle fetch.
      if (loaded && (acc || last_due >= cyc)) ready_at = (acc ? cyc + 3 : last_due) + 4;
      else ready_at = cyc + 3;
      loaded = 1;
    end
    if (acc) last_due = cyc + 3;

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 16'h0, 0, 0, 0);
  endtask

  // Offers junk vectors while not ready; none of them may produce a result.
  task automatic wait_ready();
    int n = 0;
    while (!(loaded && cyc >= ready_at) && n < 40) begin
      cycle(0, 16'h0, 1, rs8(), rs8());
      n++;
    end
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_y0"}, y0, 0);
    chk({tag, "_y1"}, y1, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    for (int t = 0; t < 16; t++)
      for (int i = 0; i < 4; i++) mem[t][i] = rs8();
    mem[1] = '{1, 2, 3, 4};
    mem[2] = '{-128, -128, -128, -128};
    mem[3] = '{127, -128, -128, 127};
    mem[4] = '{1, 0, 0, 1};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_values("reset");
    rst_n = 1'b1;
    cyc = 0;
    model_reset();

    // IDLE ignores vectors, then the basic tile
    cycle(0, 16'h0, 1, 9, 9);
    cycle(0, 16'h0, 1, 9, 9);
    cycle(1, 16'hA001, 0, 0, 0);
    idle(2);
    cycle(0, 16'h0, 1, 5, 6);
    idle(2);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_y0", y0, 23);
    chk("basic_y1", y1, 34);

    // most negative corner
    cycle(1, 16'h0002, 0, 0, 0);
    wait_ready();
    cycle(0, 16'h0, 1, -128, -128);
    idle(2);
    chk("neg_y0", y0, 32768);
    chk("neg_y1", y1, 32768);

    // mixed-sign extremes
    cycle(1, 16'h7F03, 0, 0, 0);
    wait_ready();
    cycle(0, 16'h0, 1, 127, -128);
    idle(2);
    chk("mix_y0", y0, 32513);
    chk("mix_y1", y1, -32512);

    // identity tile, 8 back-to-back vectors
    cycle(1, 16'h0004, 0, 0, 0);
    wait_ready();
    for (int k = 0; k < 8; k++) cycle(0, 16'h0, 1, k, k + 1);
    idle(4);

    // load with vectors in flight, one of them accepted in the same cycle as load_req
    cycle(0, 16'h0, 1, rs8(), rs8());
    cycle(0, 16'h0, 1, rs8(), rs8());
    cycle(1, 16'h5005, 1, rs8(), rs8());
    wait_ready();
    chk("inflight_w_addr", w_addr, 16'h5005);
    for (int k = 0; k < 4; k++) cycle(0, 16'h0, 1, rs8(), rs8());
    idle(3);

    // random traffic, loads and stalls
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 3) != 0, rs8(), rs8());
    idle(4);

    // reset in the middle of a stream
    cycle(1, 16'h0001, 0, 0, 0);
    wait_ready();
    cycle(0, 16'h0, 1, 5, 6);
    cycle(0, 16'h0, 1, 7, 8);
    cycle(0, 16'h0, 1, 1, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    load_req = 1'b0;
    #1;
    reset_values("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
    model_reset();
    for (int k = 0; k < 6; k++) cycle(0, 16'h0, 1, rs8(), rs8());
    cycle(1, 16'h0004, 0, 0, 0);
    wait_ready();
    for (int k = 0; k < 5; k++) cycle(0, 16'h0, 1, rs8(), rs8());
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
